tohost_sig_monitor: RTL and testbench
=====================================

// Module: tohost_sig_monitor
// PURPOSE
//  Synthesizable end-of-test monitor beside `top` in the compliance bench; consumes decode-stage retire info.
//  Counts retired instructions and cycles, detects the write_tohost PC reached HIT_LIMIT times, latches x3 pass/fail,
//  then reads the signature region out of DTCM via a 1-cycle-latency read port, streaming words on a valid/ready port.
// PARAMETERS
//  TOHOST_PC    32'h0000_0040  PC of the write_tohost loop instruction
//  HIT_LIMIT    8              valid retires at TOHOST_PC that end the test (>=1)
//  DTCM_AW      12             DTCM word-address width
//  TIMEOUT_CYC  32'd50000      watchdog limit, used only with SIG_TIMEOUT_EN
// PORTS
//  clk          in   1        core clock; sole clock domain
//  cpurst_n     in   1        asynchronous active-low reset
//  inst_valid   in   1        de2ex_inst_valid: one instruction retires this cycle
//  inst_pc      in   32       fe2de_pc_ffout: PC of that instruction
//  x3_val       in   32       regfile x3 (gp), live value
//  sig_base     in   32       signature start byte addr, word aligned, inclusive
//  sig_end      in   32       signature end byte addr, word aligned, exclusive
//  rd_en        out  1        DTCM read strobe, one-cycle pulse
//  rd_addr      out  DTCM_AW  DTCM word address
//  rd_data      in   32       DTCM data, valid the cycle after rd_en
//  sig_valid    out  1        signature word available
//  sig_ready    in   1        sink accepts word when sig_valid&sig_ready
//  sig_data     out  32       signature word
//  sig_last     out  1        qualifies final word
//  done         out  1        sticky: test finished, dump complete
//  pass         out  1        x3==1 at trigger edge (0 on timeout)
//  timeout      out  1        sticky watchdog flag (0 when feature absent)
//  cycle_count  out  32       cycles from reset release through trigger cycle
//  instret      out  32       inst_valid cycles through trigger cycle
// BEHAVIOUR
//  Reset: every output and register 0; state RUN. Async assert clears mid-scan at once (rd_en, sig_valid drop).
//  States: RUN -> RD -> WAIT -> PUSH -> (RD | DONE); RUN -> DONE when region empty.
//  RUN: cycle_count+1 every edge; instret+1 on inst_valid; hit_cnt+1 on inst_valid && inst_pc==TOHOST_PC.
//   Trigger = edge where hit_cnt reaches HIT_LIMIT; that edge's cycle/instret increments included, then frozen.
//   At trigger: pass<=(x3_val==32'd1); ptr<=sig_base[DTCM_AW+1:2]; words=(sig_end-sig_base)>>2, 0 if sig_end<=sig_base.
//   words==0 -> DONE directly, no stream output; else -> RD.
//  RD: rd_en=1, rd_addr=ptr for exactly one cycle -> WAIT.
//  WAIT: capture rd_data into sig_data; sig_valid<=1; sig_last<=(remaining==1) -> PUSH.
//  PUSH: sig_data/sig_last held stable while sig_valid&&!sig_ready. On handshake: sig_valid<=0, ptr+1, remaining-1;
//   last word -> DONE, else -> RD. No read overlaps an unaccepted word; peak rate 1 word / 3 cycles.
//  ptr wraps modulo 2^DTCM_AW; no bounds error raised.
//  DONE: done=1, sig_valid=0, counters frozen, inst_valid ignored; exits only via reset.
//  inst_valid/inst_pc ignored outside RUN. Counters wrap at 2^32 silently. hit_cnt saturates at HIT_LIMIT.
// CONFIGURATION
//  SIG_TIMEOUT_EN defined: RUN reaching cycle_count==TIMEOUT_CYC without trigger -> DONE, timeout=1, pass=0, no dump.
//   Trigger on the same edge as the limit wins (normal path).
//  SIG_TIMEOUT_EN undefined: no watchdog logic; timeout tied 0; RUN may persist indefinitely.
// STRUCTURE
//  Shared header tohost_mon_defs.vh: state encodings (RUN, RD, WAIT, PUSH, DONE), default TOHOST_PC/HIT_LIMIT, PASS_X3=1.
//  One sub-module: mon_cnt32 (32-bit counter, inc enable, freeze, async clear), instanced for cycle_count and instret.
//  FSM, hit counter, address pointer, output register in this module.
// TESTING
//  1 10 inst_valid at PC 0x40 after 5 other retires, x3=1, base 0x2000, end 0x2010 -> trigger on 8th hit, instret=13,
//    pass=1, 4 reads at word 0x800..0x803, 4 words streamed in order, sig_last on 4th only, done=1.
//  2 Same with x3=0 -> pass=0, dump still identical.
//  3 sig_ready low 7 cycles on word 2 -> sig_data/sig_last stable, no rd_en until accept, no word lost or duplicated.
//  4 sig_end==sig_base at trigger -> done next cycle, sig_valid never asserted, rd_en never pulsed.
//  5 cpurst_n low during PUSH -> all outputs 0 same cycle; after release, RUN restarts, cycle_count counts from 0.
//  6 SIG_TIMEOUT_EN, TIMEOUT_CYC=100, PC 0x40 never hit -> at cycle 100 done=1, timeout=1, pass=0, no reads.

Source files
------------

// File: rtl/tohost_sig_monitor_pkg.sv
// tohost_sig_monitor_pkg: shared state encodings, defaults and signature sizing helper
package tohost_sig_monitor_pkg;
   typedef enum logic [2:0] {ST_RUN, ST_RD, ST_WAIT, ST_PUSH, ST_DONE} state_e;
   localparam logic [31:0] DEF_TOHOST_PC = 32'h0000_0040;
   localparam int DEF_HIT_LIMIT = 8;
   localparam logic [31:0] PASS_X3 = 32'd1;
   // Number of words in [b, e); an empty or inverted region yields zero.
   function automatic logic [29:0] sig_words(input logic [31:0] b, input logic [31:0] e);
      return (e > b) ? 30'((e - b) >> 2) : 30'd0;
   endfunction
endpackage

// File: rtl/mon_cnt32.sv
// mon_cnt32: 32-bit wrapping counter with increment enable, freeze and async clear
module mon_cnt32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc_i,
   input  logic        frz_i,
   output logic [31:0] cnt_o
);
   logic [31:0] cnt_q;
   // Count on enabled edges unless frozen.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else if (inc_i && !frz_i) cnt_q <= cnt_q + 32'd1;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/tohost_sig_monitor.sv
// tohost_sig_monitor: end-of-test detector and DTCM signature streamer; watchdog under SIG_TIMEOUT_EN
module tohost_sig_monitor
   import tohost_sig_monitor_pkg::*;
#(
   parameter logic [31:0] TOHOST_PC   = DEF_TOHOST_PC,
   parameter int          HIT_LIMIT   = DEF_HIT_LIMIT,
   parameter int          DTCM_AW     = 12,
   parameter logic [31:0] TIMEOUT_CYC = 32'd50000
) (
   input  logic               clk,
   input  logic               cpurst_n,
   input  logic               inst_valid,
   input  logic [31:0]        inst_pc,
   input  logic [31:0]        x3_val,
   input  logic [31:0]        sig_base,
   input  logic [31:0]        sig_end,
   output logic               rd_en,
   output logic [DTCM_AW-1:0] rd_addr,
   input  logic [31:0]        rd_data,
   output logic               sig_valid,
   input  logic               sig_ready,
   output logic [31:0]        sig_data,
   output logic               sig_last,
   output logic               done,
   output logic               pass,
   output logic               timeout,
   output logic [31:0]        cycle_count,
   output logic [31:0]        instret
);
   state_e             state_q;
   logic [31:0]        hit_q;
   logic [DTCM_AW-1:0] ptr_q;
   logic [29:0]        rem_q;
   logic [31:0]        data_q;
   logic               valid_q, last_q, pass_q, tmo_q;
   logic               in_run, hit, trig, tmo_hit;
   logic [29:0]        words_d;
   assign in_run  = state_q == ST_RUN;
   assign hit     = in_run && inst_valid && inst_pc == TOHOST_PC;
   assign trig    = hit && hit_q == 32'(HIT_LIMIT - 1);
   assign words_d = sig_words(sig_base, sig_end);
`ifdef SIG_TIMEOUT_EN
   assign tmo_hit = in_run && !trig && cycle_count == TIMEOUT_CYC - 32'd1;
`else
   logic unused_timeout;
   assign tmo_hit        = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYC;
`endif
   mon_cnt32 u_cyc (.clk(clk), .rst_n(cpurst_n), .inc_i(1'b1), .frz_i(!in_run), .cnt_o(cycle_count));
   mon_cnt32 u_ret (.clk(clk), .rst_n(cpurst_n), .inc_i(inst_valid), .frz_i(!in_run), .cnt_o(instret));
   // Trigger detection, then one read / capture / handshake round per signature word.
   always_ff @(posedge clk or negedge cpurst_n)
      if (!cpurst_n) begin
         state_q <= ST_RUN;
         hit_q   <= '0;
         ptr_q   <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         pass_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else
         case (state_q)
            ST_RUN: begin
               if (hit && hit_q < 32'(HIT_LIMIT)) hit_q <= hit_q + 32'd1;
               if (trig) begin
                  pass_q  <= x3_val == PASS_X3;
                  ptr_q   <= sig_base[DTCM_AW+1:2];
                  rem_q   <= words_d;
                  state_q <= (words_d == 30'd0) ? ST_DONE : ST_RD;
               end else if (tmo_hit) begin
                  tmo_q   <= 1'b1;
                  pass_q  <= 1'b0;
                  state_q <= ST_DONE;
               end
            end
            ST_RD: state_q <= ST_WAIT;
            ST_WAIT: begin
               data_q  <= rd_data;
               valid_q <= 1'b1;
               last_q  <= rem_q == 30'd1;
               state_q <= ST_PUSH;
            end
            ST_PUSH:
               if (sig_ready) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  ptr_q   <= ptr_q + DTCM_AW'(1);
                  rem_q   <= rem_q - 30'd1;
                  state_q <= last_q ? ST_DONE : ST_RD;
               end
            default: ;
         endcase
   assign rd_en     = state_q == ST_RD;
   assign rd_addr   = ptr_q;
   assign sig_valid = valid_q;
   assign sig_data  = data_q;
   assign sig_last  = last_q;
   assign done      = state_q == ST_DONE;
   assign pass      = pass_q;
   assign timeout   = tmo_q;
endmodule

// File: tb/tb_tohost_sig_monitor.sv
// tb_tohost_sig_monitor: scoreboard bench for the tohost signature monitor
module tb_tohost_sig_monitor;
   logic        clk = 1'b0;
   logic        cpurst_n = 1'b0;
   logic        inst_valid = 1'b0;
   logic [31:0] inst_pc = '0;
   logic [31:0] x3_val = '0;
   logic [31:0] sig_base = '0;
   logic [31:0] sig_end = '0;
   logic        rd_en;
   logic [11:0] rd_addr;
   logic [31:0] rd_data = '0;
   logic        sig_valid;
   logic        sig_ready = 1'b1;
   logic [31:0] sig_data;
   logic        sig_last;
   logic        done, pass, timeout;
   logic [31:0] cycle_count, instret;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];
   logic [11:0] addr_q[$];
   logic        mon_en = 1'b0;
   int          acc_cnt = 0;
   int          stall_idx = -1;
   int          stall_left = 0;

   tohost_sig_monitor #(.TIMEOUT_CYC(32'd100)) dut (
      .clk(clk), .cpurst_n(cpurst_n), .inst_valid(inst_valid), .inst_pc(inst_pc), .x3_val(x3_val),
      .sig_base(sig_base), .sig_end(sig_end), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .sig_valid(sig_valid), .sig_ready(sig_ready), .sig_data(sig_data), .sig_last(sig_last),
      .done(done), .pass(pass), .timeout(timeout), .cycle_count(cycle_count), .instret(instret)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [11:0] a);
      return {20'hA5000, a};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event not expected or bound expired", name);
   endtask

   // Sink ready: stalls for stall_left valid cycles on word index stall_idx.
   initial forever begin
      @(posedge clk);
      #2;
      if (sig_valid && acc_cnt == stall_idx && stall_left > 0) begin
         sig_ready = 1'b0;
         stall_left--;
      end else sig_ready = 1'b1;
   end

   // DTCM model with one-cycle latency plus scoreboard monitor.
   initial begin
      logic        pend, pv, pr, pl;
      logic [11:0] pa;
      logic [31:0] pd;
      logic [32:0] e;
      logic [11:0] ea;
      pend = 1'b0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pa = '0; pd = '0;
      forever begin
         @(negedge clk);
         rd_data = pend ? mem_word(pa) : 32'hDEAD_BEEF;
         pend = cpurst_n && rd_en;
         pa = rd_addr;
         if (!mon_en) pv = 1'b0;
         else begin
            if (pv && !pr) begin
               check("hold_valid", 32'(sig_valid), 32'd1);
               check("hold_data", sig_data, pd);
               check("hold_last", 32'(sig_last), 32'(pl));
            end
            if (sig_valid) check("no_rd_while_valid", 32'(rd_en), 32'd0);
            if (sig_valid && sig_ready) begin
               if (exp_q.size() == 0) fail("unexpected_word");
               else begin
                  e = exp_q.pop_front();
                  check("word_data", sig_data, e[31:0]);
                  check("word_last", 32'(sig_last), 32'(e[32]));
               end
               acc_cnt++;
            end
            if (rd_en) begin
               if (addr_q.size() == 0) fail("unexpected_read");
               else begin
                  ea = addr_q.pop_front();
                  check("rd_addr", 32'(rd_addr), 32'(ea));
               end
            end
            pv = sig_valid; pr = sig_ready; pd = sig_data; pl = sig_last;
         end
      end
   end

   task automatic do_reset();
      mon_en = 1'b0;
      cpurst_n = 1'b0;
      inst_valid = 1'b0;
      inst_pc = '0;
      exp_q.delete();
      addr_q.delete();
      acc_cnt = 0;
      stall_idx = -1;
      stall_left = 0;
      repeat (2) @(negedge clk);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sig_valid", 32'(sig_valid), 32'd0);
      check("rst_rd_en", 32'(rd_en), 32'd0);
      check("rst_cycle_count", cycle_count, 32'd0);
      check("rst_instret", instret, 32'd0);
   endtask

   // Reset, load expectations, release and retire 5 non-tohost + 10 tohost instructions.
   task automatic start(input logic [31:0] x3, input logic [31:0] b, input logic [31:0] e,
                        input int n, input logic [11:0] w0, input int s_idx, input int s_len);
      do_reset();
      for (int i = 0; i < n; i++) begin
         addr_q.push_back(12'(w0 + 12'(i)));
         exp_q.push_back({i == n - 1, mem_word(12'(w0 + 12'(i)))});
      end
      stall_idx = s_idx;
      stall_left = s_len;
      x3_val = x3;
      sig_base = b;
      sig_end = e;
      cpurst_n = 1'b1;
      mon_en = 1'b1;
      for (int k = 0; k < 15; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 13) begin
            if (n == 0) check("done_next_cycle", 32'(done), 32'd1);
            else check("rd_after_trigger", 32'(rd_en), 32'd1);
         end
         inst_valid = 1'b1;
         inst_pc = (k < 5) ? 32'h100 + 32'(4 * k) : 32'h40;
      end
      @(negedge clk);
      inst_valid = 1'b0;
   endtask

   task automatic finish_chk(input logic pass_e, input int n);
      int t;
      t = 0;
      while (!done && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!done) fail("done_wait");
      repeat (2) @(negedge clk);
      check("done", 32'(done), 32'd1);
      check("pass", 32'(pass), 32'(pass_e));
      check("timeout", 32'(timeout), 32'd0);
      check("instret", instret, 32'd13);
      check("cycle_count", cycle_count, 32'd13);
      check("sig_valid_idle", 32'(sig_valid), 32'd0);
      check("words_accepted", 32'(acc_cnt), 32'(n));
      check("words_left", 32'(exp_q.size()), 32'd0);
      check("reads_left", 32'(addr_q.size()), 32'd0);
   endtask

   initial begin
      int t;
      // 1: normal dump, pass
      start(32'd1, 32'h2000, 32'h2010, 4, 12'h800, -1, 0);
      finish_chk(1'b1, 4);
      // 2: same region, x3 = 0
      start(32'd0, 32'h2000, 32'h2010, 4, 12'h800, -1, 0);
      finish_chk(1'b0, 4);
      // 3: backpressure on the second word
      start(32'd1, 32'h2000, 32'h2010, 4, 12'h800, 1, 7);
      finish_chk(1'b1, 4);
      // 4: empty region, then inverted region
      start(32'd1, 32'h3000, 32'h3000, 0, 12'h0, -1, 0);
      finish_chk(1'b1, 0);
      start(32'd1, 32'h2010, 32'h2000, 0, 12'h0, -1, 0);
      finish_chk(1'b1, 0);
      // pointer wraps past the top of the DTCM
      start(32'd1, 32'h3FF8, 32'h4008, 4, 12'hFFE, -1, 0);
      finish_chk(1'b1, 4);
      // 5: reset asserted while a word waits for acceptance
      start(32'd1, 32'h2000, 32'h2010, 4, 12'h800, 0, 1000);
      t = 0;
      while (!sig_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!sig_valid) fail("push_wait");
      repeat (2) @(negedge clk);
      mon_en = 1'b0;
      cpurst_n = 1'b0;
      #1;
      check("async_sig_valid", 32'(sig_valid), 32'd0);
      check("async_sig_data", sig_data, 32'd0);
      check("async_sig_last", 32'(sig_last), 32'd0);
      check("async_rd_en", 32'(rd_en), 32'd0);
      check("async_done", 32'(done), 32'd0);
      check("async_pass", 32'(pass), 32'd0);
      check("async_cycle_count", cycle_count, 32'd0);
      check("async_instret", instret, 32'd0);
      exp_q.delete();
      addr_q.delete();
      stall_left = 0;
      @(negedge clk);
      cpurst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("restart_cycle_count", cycle_count, 32'd5);
      check("restart_instret", instret, 32'd0);
      check("restart_done", 32'(done), 32'd0);
`ifdef SIG_TIMEOUT_EN
      // 6: watchdog with tohost never reached
      do_reset();
      x3_val = 32'd1;
      sig_base = 32'h2000;
      sig_end = 32'h2010;
      cpurst_n = 1'b1;
      mon_en = 1'b1;
      repeat (99) @(negedge clk);
      check("tmo_not_yet", 32'(done), 32'd0);
      @(negedge clk);
      check("tmo_done", 32'(done), 32'd1);
      check("tmo_flag", 32'(timeout), 32'd1);
      check("tmo_pass", 32'(pass), 32'd0);
      check("tmo_cycle_count", cycle_count, 32'd100);
      repeat (3) @(negedge clk);
      check("tmo_frozen", cycle_count, 32'd100);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
